// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial add/subtract unit: FSM state
// encoding, operation mode constants and the digit-counter width helper.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Counter width for n digits, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle of the serial add/subtract unit.
//
// Handshake: the requester raises start together with mode, a, b and cin;
// the unit samples them on a rising edge only while idle or in its done
// cycle (start during an operation is ignored). busy is high while an
// operation is in flight, done pulses for exactly one cycle when y, cout
// and ovf have been updated; those results hold until the next completion.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, a, b, cin,
        input  busy, done, y, cout, ovf
    );

    modport slave (
        input  start, mode, a, b, cin,
        output busy, done, y, cout, ovf
    );
endinterface

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    // Sum and majority carry.
    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end
endmodule

// File: rtl/serial_addsub_rca_digit.sv
// DIGIT-wide ripple-carry chain of fa cells. Besides the sum digit and
// carry out it exposes the carry entering the top bit, which together with
// the carry out gives signed overflow on the most significant digit.
module rca_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o,
    output logic             c_msb_o
);
    logic [DIGIT:0] c;

    assign c[0]    = c_i;
    assign c_o     = c[DIGIT];
    assign c_msb_o = c[DIGIT-1];

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        fa u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (c[i]),
            .s_o (s_o[i]),
            .c_o (c[i+1])
        );
    end
endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract unit. Operands are walked LSB first, DIGIT bits
// per clock, through rca_digit. Subtraction is a + ~b + ~cin, so cout=1
// means "no borrow". Results become visible only on the completing edge.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    serial_addsub_if.slave  bus,
    output state_e          state_o
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q, b_q, s_q;
    logic               carry_q;
    logic [WIDTH-1:0]   y_q;
    logic               cout_q, ovf_q;

    logic               accept, last;
    logic [DIGIT-1:0]   sum_dig;
    logic               dig_cout, dig_cmsb;
    logic [WIDTH-1:0]   s_shift;

    rca_digit #(.DIGIT(DIGIT)) u_rca (
        .a_i     (a_q[DIGIT-1:0]),
        .b_i     (b_q[DIGIT-1:0]),
        .c_i     (carry_q),
        .s_o     (sum_dig),
        .c_o     (dig_cout),
        .c_msb_o (dig_cmsb)
    );

    // New sum digit enters at the MSB while the partial result moves down.
    always_comb begin
        s_shift = (s_q >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, start acceptance and last-digit detection.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                    last    = 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand/result shift registers, carry and digit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= (bus.mode == SUB) ? ~bus.b : bus.b;
            carry_q <= bus.cin ^ bus.mode;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            s_q     <= s_shift;
            carry_q <= dig_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Output registers, updated only on the completing digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last) begin
            y_q    <= s_shift;
            cout_q <= dig_cout;
            ovf_q  <= dig_cmsb ^ dig_cout;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.y    = y_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign state_o  = state_q;
endmodule
